// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the LEGv8 datapath and muldiv_unit.
// Core side drives the request; the unit drives status and write-back.
interface muldiv_unit_if #(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
);
  logic              iStart;
  logic [2:0]        iOp;
  logic [WIDTH-1:0]  iOperandA;
  logic [WIDTH-1:0]  iOperandB;
  logic [REG_AW-1:0] iDestReg;
  logic              oBusy;
  logic              oStall;
  logic              oDone;
  logic              oRegWrite;
  logic [REG_AW-1:0] oWriteRegister;
  logic [WIDTH-1:0]  oResult;

  modport master (
    output iStart, iOp, iOperandA, iOperandB, iDestReg,
    input  oBusy, oStall, oDone, oRegWrite, oWriteRegister, oResult
  );

  modport slave (
    input  iStart, iOp, iOperandA, iOperandB, iDestReg,
    output oBusy, oStall, oDone, oRegWrite, oWriteRegister, oResult
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MUL/SMULH/UMULH/SDIV/UDIV unit for the LEGv8 datapath.
// One radix-2 step per cycle; every op completes WIDTH cycles after capture.
module muldiv_unit #(
  parameter int WIDTH  = 64,
  parameter int REG_AW = 5
) (
  input logic          iCLK,
  input logic          iRST,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_SMULH = 3'd1;
  localparam logic [2:0] OP_UMULH = 3'd2;
  localparam logic [2:0] OP_SDIV  = 3'd3;
  localparam logic [2:0] OP_UDIV  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              dz_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  d_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  res_q;
  logic [REG_AW-1:0] wr_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] cap_lo;
  logic             cap_neg;
  logic             sgn_diff;

  // Signed ops run on magnitudes; the sign is reapplied at the end.
  always_comb begin
    a_abs    = bus.iOperandA[WIDTH-1] ? -bus.iOperandA : bus.iOperandA;
    b_abs    = bus.iOperandB[WIDTH-1] ? -bus.iOperandB : bus.iOperandB;
    sgn_diff = bus.iOperandA[WIDTH-1] ^ bus.iOperandB[WIDTH-1];
    cap_d    = '0;
    cap_lo   = '0;
    cap_neg  = 1'b0;
    unique case (1'b1)
      bus.iOp == OP_MUL,
      bus.iOp == OP_UMULH: begin
        cap_d  = bus.iOperandA;
        cap_lo = bus.iOperandB;
      end
      bus.iOp == OP_SMULH: begin
        cap_d   = a_abs;
        cap_lo  = b_abs;
        cap_neg = sgn_diff;
      end
      bus.iOp == OP_SDIV: begin
        cap_d   = b_abs;
        cap_lo  = a_abs;
        cap_neg = sgn_diff;
      end
      bus.iOp == OP_UDIV: begin
        cap_d  = bus.iOperandB;
        cap_lo = bus.iOperandA;
      end
      default: begin
        cap_d  = '0;
        cap_lo = '0;
      end
    endcase
  end

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic               is_div;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_d;

  // hi/lo is the product accumulator for multiplies and the
  // remainder/quotient pair for divides.
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    sh     = {hi_q, lo_q[WIDTH-1]};
    diff   = sh - {1'b0, d_q};
    ge     = ~diff[WIDTH];
    is_div = (op_q == OP_SDIV) || (op_q == OP_UDIV);
    if (is_div) begin
      hi_d = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
    prod_raw = {hi_d, lo_d};
    prod     = neg_q ? -prod_raw : prod_raw;
    res_d    = '0;
    unique case (1'b1)
      op_q == OP_MUL:   res_d = prod[WIDTH-1:0];
      op_q == OP_SMULH,
      op_q == OP_UMULH: res_d = prod[2*WIDTH-1:WIDTH];
      op_q == OP_SDIV,
      op_q == OP_UDIV:  res_d = dz_q ? '0 : prod[WIDTH-1:0];
      default:          res_d = '0;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      wr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.iStart) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            op_q    <= bus.iOp;
            neg_q   <= cap_neg;
            dz_q    <= (bus.iOperandB == '0);
            d_q     <= cap_d;
            hi_q    <= '0;
            lo_q    <= cap_lo;
            wr_q    <= bus.iDestReg;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            res_q   <= res_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oBusy          = busy_q;
  assign bus.oStall         = ((state_q == IDLE) && bus.iStart) || (state_q == RUN);
  assign bus.oDone          = done_q;
  assign bus.oRegWrite      = done_q;
  assign bus.oWriteRegister = wr_q;
  assign bus.oResult        = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model,
// directed literal cases and a randomized phase.
module tb_muldiv_unit;
  localparam int W = 64;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W), .REG_AW(5)) bus ();
  muldiv_unit #(.WIDTH(W), .REG_AW(5)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;

  logic        inflt   = 1'b0;
  int          done_at = 0;
  int          free_at = 0;
  logic [63:0] exp_res = '0;
  logic [4:0]  exp_wr  = '0;
  logic [63:0] res_hold = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return MIN;
      2: return ONES;
      3: return 64'($urandom_range(0, 20));
      4: return -64'($urandom_range(1, 20));
      default: return rnd64();
    endcase
  endfunction

  function automatic logic [63:0] ref_f(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [127:0]        up;
    logic signed [127:0] sp;
    logic signed [63:0]  sa;
    logic signed [63:0]  sb;
    up = {64'd0, a} * {64'd0, b};
    sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    sa = a;
    sb = b;
    case (op)
      3'd0: return up[63:0];
      3'd1: return sp[127:64];
      3'd2: return up[127:64];
      3'd3: begin
        if (b == 64'd0) return 64'd0;
        if (a == MIN && b == ONES) return MIN;
        return 64'(sa / sb);
      end
      3'd4: return (b == 64'd0) ? 64'd0 : a / b;
      default: return 64'd0;
    endcase
  endfunction

  // Model: an accepted op completes 64 edges later; the unit is free
  // again one edge after that, so the next accept is one edge later still.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      inflt   = 1'b0;
      free_at = cyc;
    end else if (bus.iStart && cyc > free_at) begin
      inflt   = 1'b1;
      done_at = cyc + 64;
      free_at = cyc + 65;
      exp_res = ref_f(bus.iOp, bus.iOperandA, bus.iOperandB);
      exp_wr  = bus.iDestReg;
    end
  end

  always @(negedge clk) begin
    logic b;
    logic d;
    if (rst) begin
      res_hold = '0;
    end else begin
      b = inflt && (cyc <= done_at);
      d = inflt && (cyc == done_at);
      chk("busy", 64'(bus.oBusy), 64'(b));
      chk("stall", 64'(bus.oStall),
          64'((inflt && cyc < done_at) || (!b && bus.iStart)));
      chk("done", 64'(bus.oDone), 64'(d));
      chk("regwrite", 64'(bus.oRegWrite), 64'(d));
      if (d) begin
        chk("result", bus.oResult, exp_res);
        chk("dest", 64'(bus.oWriteRegister), 64'(exp_wr));
        res_hold = exp_res;
        n_done++;
      end else if (!b) begin
        chk("held_result", bus.oResult, res_hold);
      end
    end
  end

  task automatic drive(logic st, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                       logic [4:0] d);
    @(posedge clk);
    #1;
    bus.iStart    = st;
    bus.iOp       = op;
    bus.iOperandA = a;
    bus.iOperandB = b;
    bus.iDestReg  = d;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 3'($urandom), rnd64(), rnd64(), 5'($urandom));
  endtask

  task automatic run_op(string nm, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                        logic [4:0] d, logic [63:0] exp);
    int t0;
    logic seen;
    seen = 1'b0;
    drive(1'b1, op, a, b, d);
    t0 = cyc;
    drive(1'b0, 3'($urandom), rnd64(), rnd64(), 5'($urandom));
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.oDone;
    end
    chk({nm, "_done"}, 64'(bus.oDone), 64'd1);
    chk({nm, "_result"}, bus.oResult, exp);
    chk({nm, "_dest"}, 64'(bus.oWriteRegister), 64'(d));
    chk({nm, "_latency"}, 64'(cyc - t0 - 1), 64'd64);
    idle(2);
  endtask

  initial begin
    int t0;
    int cnt;
    int nd;
    int d1;
    int d2;
    bus.iStart    = 1'b0;
    bus.iOp       = '0;
    bus.iOperandA = '0;
    bus.iOperandB = '0;
    bus.iDestReg  = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.oBusy), 64'd0);
    chk("rst_done", 64'(bus.oDone), 64'd0);
    chk("rst_regwrite", 64'(bus.oRegWrite), 64'd0);
    chk("rst_result", bus.oResult, 64'd0);
    chk("rst_dest", 64'(bus.oWriteRegister), 64'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    run_op("mul", 3'd0, ONES, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("smulh", 3'd1, ONES, 64'd2, 5'd9, ONES);
    run_op("umulh", 3'd2, ONES, 64'd2, 5'd9, 64'd1);

    // Reset half a cycle after the tenth RUN edge.
    drive(1'b1, 3'd4, 64'd1000, 64'd3, 5'd7);
    t0 = cyc;
    idle(1);
    while (cyc < t0 + 11) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.oBusy), 64'd0);
    chk("mid_rst_stall", 64'(bus.oStall), 64'd0);
    chk("mid_rst_done", 64'(bus.oDone), 64'd0);
    chk("mid_rst_regwrite", 64'(bus.oRegWrite), 64'd0);
    chk("mid_rst_result", bus.oResult, 64'd0);
    chk("mid_rst_dest", 64'(bus.oWriteRegister), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.oDone) cnt++;
    end
    chk("no_done_after_rst", 64'(cnt), 64'd0);
    run_op("mul_3x5", 3'd0, 64'd3, 64'd5, 5'd4, 64'd15);

    run_op("sdiv_m7_2", 3'd3, -64'd7, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("udiv_100_7", 3'd4, 64'd100, 64'd7, 5'd2, 64'd14);
    run_op("sdiv_min_m1", 3'd3, MIN, ONES, 5'd3, MIN);
    run_op("udiv_by0", 3'd4, 64'd42, 64'd0, 5'd5, 64'd0);
    run_op("sdiv_by0", 3'd3, -64'd5, 64'd0, 5'd6, 64'd0);
    run_op("illegal6", 3'd6, rnd64(), rnd64(), 5'd31, 64'd0);

    // iStart held high with operands churning every cycle.
    drive(1'b1, 3'd4, 64'd100, 64'd7, 5'd3);
    nd = 0;
    d1 = 0;
    d2 = 0;
    for (int i = 0; i < 300 && nd < 2; i++) begin
      @(negedge clk);
      if (bus.oDone) begin
        nd++;
        if (nd == 1) begin
          d1 = cyc;
          chk("hs_first_result", bus.oResult, 64'd14);
        end else begin
          d2 = cyc;
        end
      end
      if (nd < 2) drive(1'b1, 3'd4, rnd64(), pick(), 5'd3);
    end
    chk("hs_count", 64'(nd), 64'd2);
    chk("hs_gap", 64'(d2 - d1), 64'd66);
    idle(3);

    cnt = n_done;
    repeat (3000) begin
      drive($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), pick(), pick(),
            5'($urandom));
    end
    idle(100);
    chk("rand_ops_seen", 64'(n_done - cnt > 20), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
